// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single-precision field widths, extended
// mantissa bit positions, special word constants and the normalizer state enum.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = FRAC_W + 4;  // carry, hidden, fraction, guard, sticky

  localparam logic [EXP_W-1:0] BIAS_MAX = 8'd255;

  // Bit positions inside the 27-bit extended mantissa
  localparam int CARRY  = 26;
  localparam int HIDDEN = 25;
  localparam int GUARD  = 1;
  localparam int STICKY = 0;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] INF  = 32'h7F80_0000;
  localparam logic [31:0] ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ROUND,
    DONE
  } state_e;

endpackage

// File: rtl/fpu_round_rne.sv
// Combinational round-to-nearest-even of a 24-bit significand using its
// guard and sticky bits; a carry out renormalizes the significand to 1.0.
module fpu_round_rne
  import fpu_pkg::*;
(
  input  logic [FRAC_W:0] sig_in,
  input  logic            guard,
  input  logic            sticky,
  output logic [FRAC_W:0] sig_out,
  output logic            carry
);

  logic              inc;
  logic [FRAC_W+1:0] sum;

  // Ties (guard set, sticky clear) round up only when the lsb is odd
  assign inc     = guard & (sticky | sig_in[0]);
  assign sum     = {1'b0, sig_in} + {{(FRAC_W + 1){1'b0}}, inc};
  assign carry   = sum[FRAC_W+1];
  assign sig_out = carry ? {1'b1, {FRAC_W{1'b0}}} : sum[FRAC_W:0];

endmodule

// File: rtl/fpu_normalize.sv
// FPU back end: renormalizes a raw add/sub result one bit per cycle, rounds
// to nearest-even and packs a single-precision word behind valid/ready.
module fpu_normalize
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exponent,
  input  logic [MANT_W-1:0] in_mantissa,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       result,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [9:0] EXP_INF = {2'b00, BIAS_MAX};

  state_e            state_q, state_d;
  logic              sign_q, sign_d;
  logic [9:0]        exp_q, exp_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [31:0]       result_q, result_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic [FRAC_W:0]   rnd_sig;
  logic              rnd_carry;
  logic [9:0]        exp_inc, exp_dec, exp_rnd;

  fpu_round_rne u_round (
    .sig_in  (mant_q[HIDDEN:GUARD+1]),
    .guard   (mant_q[GUARD]),
    .sticky  (mant_q[STICKY]),
    .sig_out (rnd_sig),
    .carry   (rnd_carry)
  );

  assign exp_inc = exp_q + 10'd1;
  assign exp_dec = exp_q - 10'd1;
  assign exp_rnd = exp_q + {9'd0, rnd_carry};

  // NOTE: synchronous reset also clears the datapath registers so a result
  // abandoned mid-operation can never leak out after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      result_q    <= ZERO;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the
      // same edge independent of statement order.
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default assignments up front mean no path leaves a
    // signal unassigned, so no latch can be inferred.
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d      = in_sign;
          exp_d       = {2'b00, in_exponent};
          mant_d      = in_mantissa;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          if (in_exponent == BIAS_MAX) begin
            result_d = {in_sign, BIAS_MAX, in_mantissa[HIDDEN-1:GUARD+1]};
            state_d  = DONE;
          end else if (in_mantissa == '0) begin
            result_d = ZERO;
            state_d  = DONE;
          end else if (in_exponent == '0) begin
            result_d    = {in_sign, ZERO[30:0]};
            underflow_d = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end

      SHIFT: begin
        if (mant_q[CARRY]) begin
          // Bits shifted out of the guard position fold into sticky
          mant_d = {1'b0, mant_q[CARRY:GUARD+1], mant_q[GUARD] | mant_q[STICKY]};
          exp_d  = exp_inc;
          if (exp_inc == EXP_INF) begin
            result_d   = {sign_q, INF[30:0]};
            overflow_d = 1'b1;
            state_d    = DONE;
          end
        end else if (!mant_q[HIDDEN]) begin
          if (exp_q <= 10'd1) begin
            result_d    = {sign_q, ZERO[30:0]};
            underflow_d = 1'b1;
            state_d     = DONE;
          end else begin
            mant_d = {mant_q[MANT_W-2:0], 1'b0};
            exp_d  = exp_dec;
          end
        end else begin
          state_d = ROUND;
        end
      end

      ROUND: begin
        exp_d  = exp_rnd;
        mant_d = {1'b0, rnd_sig, 2'b00};
        if (exp_rnd == EXP_INF) begin
          result_d   = {sign_q, INF[30:0]};
          overflow_d = 1'b1;
        end else begin
          result_d = {sign_q, exp_rnd[EXP_W-1:0], rnd_sig[FRAC_W-1:0]};
        end
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    result    = result_q;
    overflow  = overflow_q;
    underflow = underflow_q;
  end

endmodule

// File: tb/tb_fpu_normalize.sv
// Directed bench for fpu_normalize: packing, rounding, overflow/underflow,
// specials, handshake stalls and synchronous reset mid-operation.
module tb_fpu_normalize;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exponent;
  logic [26:0] in_mantissa;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  int passed = 0;
  int total  = 0;

  fpu_normalize dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_exponent (in_exponent),
    .in_mantissa (in_mantissa),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present one operation in IDLE, count edges after the accept edge until
  // out_valid, check the packed word and flags, then release the result.
  task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                        input logic [26:0] m, input logic [31:0] exp_res,
                        input logic exp_ovf, input logic exp_unf, input int exp_lat);
    int n;
    in_sign     = s;
    in_exponent = e;
    in_mantissa = m;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
    check({tag, "_underflow"}, {31'd0, underflow}, {31'd0, exp_unf});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_back_to_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_sign     = 1'b0;
    in_exponent = '0;
    in_mantissa = '0;
    out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_flags", {30'd0, overflow, underflow}, 32'd0);
    rst_n = 1'b1;

    // Normal paths: latency is 2 + number of shifts
    run_op("add_carry", 1'b0, 8'd127, 27'h580_0000, 32'h4030_0000, 1'b0, 1'b0, 3);
    run_op("cancel", 1'b0, 8'd127, 27'h080_0000, 32'h3E80_0000, 1'b0, 1'b0, 4);
    run_op("cancel_neg", 1'b1, 8'd127, 27'h080_0000, 32'hBE80_0000, 1'b0, 1'b0, 4);
    run_op("tie_odd_up", 1'b0, 8'd127, 27'h3FF_FFFE, 32'h4000_0000, 1'b0, 1'b0, 2);
    run_op("tie_even_keep", 1'b0, 8'd127, 27'h3FF_FFFA, 32'h3FFF_FFFE, 1'b0, 1'b0, 2);
    run_op("above_half_up", 1'b0, 8'd127, 27'h3FF_FFFB, 32'h3FFF_FFFF, 1'b0, 1'b0, 2);
    run_op("min_normal", 1'b0, 8'd2, 27'h100_0000, 32'h0080_0000, 1'b0, 1'b0, 3);

    // Overflow and underflow boundaries
    run_op("ovf_shift", 1'b0, 8'd254, 27'h400_0000, 32'h7F80_0000, 1'b1, 1'b0, 1);
    run_op("ovf_round", 1'b0, 8'd254, 27'h3FF_FFFE, 32'h7F80_0000, 1'b1, 1'b0, 2);
    run_op("unf_shift", 1'b1, 8'd1, 27'h040_0000, 32'h8000_0000, 1'b0, 1'b1, 1);

    // Specials resolve on the accepting edge
    run_op("nan_pass", 1'b1, 8'd255, 27'h200_0004, 32'hFF80_0001, 1'b0, 1'b0, 0);
    run_op("exp_zero", 1'b1, 8'd0, 27'h200_0000, 32'h8000_0000, 1'b0, 1'b1, 0);
    run_op("flags_clear", 1'b0, 8'd127, 27'h200_0000, 32'h3F80_0000, 1'b0, 1'b0, 2);

    // Handshake: zero result, stalled consumer, producer holding the next op
    in_sign     = 1'b1;
    in_exponent = 8'd50;
    in_mantissa = '0;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    check("hs_zero_valid", {31'd0, out_valid}, 32'd1);
    check("hs_zero_result", result, 32'h0);
    in_sign     = 1'b1;
    in_exponent = 8'd255;
    in_mantissa = 27'h200_0004;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hs_stall_result", result, 32'h0);
      check("hs_stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs_release_valid", {31'd0, out_valid}, 32'd0);
    check("hs_release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("hs_second_valid", {31'd0, out_valid}, 32'd1);
    check("hs_second_result", result, 32'hFF80_0001);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during a long left-shift sequence
    in_sign     = 1'b0;
    in_exponent = 8'd127;
    in_mantissa = 27'h000_0010;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_shift_busy", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_result", result, 32'h0);
    run_op("fresh_after_rst", 1'b0, 8'd127, 27'h000_0010, 32'h3500_0000, 1'b0, 1'b0, 23);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
